// File: rtl/reg_pkg.sv
// Shared constants for the reg_32 register slice.
// Default data width and reset value used by reg_32.
package reg_pkg;

    localparam int REG_WIDTH = 32;

    localparam logic [REG_WIDTH-1:0] REG_RESET_VALUE = '0;

endpackage

// File: rtl/reg_bit_cell.sv
// One-bit storage cell: synchronous reset to a per-bit value,
// load-enabled capture, hold otherwise.
module reg_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    // rst is checked first so a reset edge discards any pending load
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= rst_val;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_32.sv
// Parameterised load-enable register built from reg_bit_cell slices.
// q comes straight from the cell flops; no path from d or load.
module reg_32
    import reg_pkg::*;
#(
    parameter int               WIDTH       = REG_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(REG_RESET_VALUE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        reg_bit_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .d       (d[i]),
            .rst_val (RESET_VALUE[i]),
            .q       (q[i])
        );
    end

`ifndef SYNTHESIS
    // Checks are only meaningful once a reset edge has defined q
    logic seen_rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            seen_rst <= 1'b1;
        end
    end

    a_reset : assert property (
        @(posedge clk) rst |=> (q == RESET_VALUE)
    );

    a_load : assert property (
        @(posedge clk) disable iff (!seen_rst)
        (load && !rst) |=> (q == $past(d))
    );

    a_hold : assert property (
        @(posedge clk) disable iff (!seen_rst)
        (!load && !rst) |=> (q == $past(q))
    );

    a_no_x : assert property (
        @(posedge clk) seen_rst |-> !$isunknown(q)
    );
`endif

endmodule

// File: tb/tb_reg_32.sv
// Directed self-checking bench for reg_32.
// Expected values are hand-computed constants.
module tb_reg_32;

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] d;
    logic [31:0] q;

    int errors;
    int checks;

    reg_32 dut (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .d    (d),
        .q    (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pat;
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        load   = 1'b1;
        d      = 32'h4;
        #2;

        tick();
        check("reset_e1", q, 32'h0000_0000);
        tick();
        check("reset_e2", q, 32'h0000_0000);

        rst  = 1'b0;
        load = 1'b1;
        d    = 32'h4;
        tick();
        check("load_4", q, 32'h0000_0004);
        d = 32'hF4;
        tick();
        check("load_f4", q, 32'h0000_00F4);

        load = 1'b0;
        d    = 32'hA4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_f4", q, 32'h0000_00F4);
        end

        load = 1'b1;
        d    = 32'h5555_5555;
        #3;
        check("no_transp", q, 32'h0000_00F4);
        load = 1'b0;
        tick();
        check("mid_glitch", q, 32'h0000_00F4);

        rst  = 1'b1;
        load = 1'b1;
        d    = 32'hFFFF_FFFF;
        tick();
        check("rst_prio", q, 32'h0000_0000);

        rst  = 1'b0;
        load = 1'b1;
        d    = 32'h1234_5678;
        tick();
        check("mid_load", q, 32'h1234_5678);
        rst = 1'b1;
        tick();
        check("mid_rst", q, 32'h0000_0000);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        check("mid_after1", q, 32'h0000_0000);
        tick();
        check("mid_after2", q, 32'h0000_0000);

        load = 1'b1;
        d    = 32'hCAFE_F00D;
        tick();
        check("pre_async", q, 32'hCAFE_F00D);
        load = 1'b0;
        rst  = 1'b1;
        #3;
        check("rst_sync", q, 32'hCAFE_F00D);
        tick();
        check("rst_edge", q, 32'h0000_0000);
        rst = 1'b0;

        load = 1'b1;
        d    = 32'hFFFF_FFFF;
        tick();
        check("all_ones", q, 32'hFFFF_FFFF);
        d = 32'h8000_0001;
        tick();
        check("msb_lsb", q, 32'h8000_0001);

        for (int i = 0; i < 32; i++) begin
            pat = 32'h1 << i;
            d   = pat;
            tick();
            check("walk_one", q, pat);
        end
        for (int i = 0; i < 32; i++) begin
            pat = ~(32'h1 << i);
            d   = pat;
            tick();
            check("walk_zero", q, pat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
